// File: rtl/regfile_sb.sv
// Dual-write, dual-read register file with a pending-register scoreboard.
// State updates on the falling clock edge; clrn clears everything asynchronously.
module regfile_sb #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] wn0,
  input  logic [AW-1:0] wn1,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic          issue,
  input  logic [AW-1:0] issue_rd,
  output logic          busy_a,
  output logic          busy_b,
  output logic [AW:0]   busy_cnt,
  output logic          ovf
);

  localparam int N = 1 << AW;
  localparam bit Z = (ZERO_R0 != 0);
  localparam bit B = (BYPASS != 0);

  logic [DW-1:0] regs [N];
  logic [N-1:0]  busy;
  logic [N-1:0]  busy_nxt;
  logic [AW:0]   cnt_nxt;
  logic          iss_v;
  logic          w0_v;
  logic          w1_v;
  logic          inc;
  logic          dec0;
  logic          dec1;
  logic          ovf_set;

  assign iss_v = issue && !(Z && issue_rd == '0);
  assign w1_v  = we1 && !(Z && wn1 == '0);
  assign w0_v  = we0 && !(Z && wn0 == '0)
               && !(we1 && wn1 == wn0);

  always_comb begin
    busy_nxt = busy;
    if (we0) busy_nxt[wn0] = 1'b0;
    if (we1) busy_nxt[wn1] = 1'b0;
    if (iss_v) busy_nxt[issue_rd] = 1'b1;
    if (Z) busy_nxt[0] = 1'b0;
  end

  // Count only real 0->1 and 1->0 transitions so the counter never wraps.
  assign inc  = iss_v && !busy[issue_rd];
  assign dec0 = we0 && busy[wn0]
              && !(iss_v && issue_rd == wn0)
              && !(we1 && wn1 == wn0);
  assign dec1 = we1 && busy[wn1]
              && !(iss_v && issue_rd == wn1);

  assign cnt_nxt = busy_cnt
                 + {{AW{1'b0}}, inc}
                 - {{AW{1'b0}}, dec0}
                 - {{AW{1'b0}}, dec1};

  assign ovf_set = iss_v && busy[issue_rd]
                 && !(we0 && wn0 == issue_rd)
                 && !(we1 && wn1 == issue_rd);

  always_ff @(negedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (w0_v) regs[wn0] <= d0;
      if (w1_v) regs[wn1] <= d1;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      if (ovf_set) ovf <= 1'b1;
    end
  end

  always_comb begin
    if (!clrn || (Z && rna == '0))   qa = '0;
    else if (B && we1 && rna == wn1) qa = d1;
    else if (B && we0 && rna == wn0) qa = d0;
    else                             qa = regs[rna];
  end

  always_comb begin
    if (!clrn || (Z && rnb == '0))   qb = '0;
    else if (B && we1 && rnb == wn1) qb = d1;
    else if (B && we0 && rnb == wn0) qb = d0;
    else                             qb = regs[rnb];
  end

  assign busy_a = clrn && busy[rna] && !(Z && rna == '0);
  assign busy_b = clrn && busy[rnb] && !(Z && rnb == '0);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, collisions, bypass, r0, scoreboard, ovf.
// A second instance with BYPASS=0 shares the inputs.
module tb_regfile_sb;

  logic        clk;
  logic        clrn;
  logic [4:0]  rna, rnb, wn0, wn1, issue_rd;
  logic        we0, we1, issue;
  logic [31:0] d0, d1;
  logic [31:0] qa, qb, qa2, qb2;
  logic        busy_a, busy_b, ovf;
  logic        busy_a2, busy_b2, ovf2;
  logic [5:0]  busy_cnt, busy_cnt2;

  int checks;
  int failures;

  regfile_sb dut (
    .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb),
    .qa(qa), .qb(qb), .we0(we0), .we1(we1),
    .wn0(wn0), .wn1(wn1), .d0(d0), .d1(d1),
    .issue(issue), .issue_rd(issue_rd),
    .busy_a(busy_a), .busy_b(busy_b),
    .busy_cnt(busy_cnt), .ovf(ovf)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb),
    .qa(qa2), .qb(qb2), .we0(we0), .we1(we1),
    .wn0(wn0), .wn1(wn1), .d0(d0), .d1(d1),
    .issue(issue), .issue_rd(issue_rd),
    .busy_a(busy_a2), .busy_b(busy_b2),
    .busy_cnt(busy_cnt2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; issue = 0;
    wn0 = 0; wn1 = 0; issue_rd = 0;
    d0 = 0; d1 = 0;
  endtask

  task automatic test_reset();
    clrn = 0; rna = 0; rnb = 0;
    idle();
    #3;
    checks++;
    if ({qa, qb, busy_a, busy_b, busy_cnt, ovf} !== '0) begin
      failures++;
      $display("FAIL reset_outs got qa=%h qb=%h cnt=%0d ovf=%b exp 0",
               qa, qb, busy_cnt, ovf);
    end
    we0 = 1; wn0 = 2; d0 = 32'h55; issue = 1; issue_rd = 2; rna = 2;
    #1;
    checks++;
    if (qa !== 32'h0) begin
      failures++;
      $display("FAIL reset_nobypass got=%h exp=0", qa);
    end
    tick(); tick();
    idle();
    clrn = 1;
    #1;
    checks++;
    if (qa !== 32'h0 || busy_a !== 1'b0 || busy_cnt !== 6'd0) begin
      failures++;
      $display("FAIL reset_blocks got qa=%h busy=%b cnt=%0d exp 0/0/0",
               qa, busy_a, busy_cnt);
    end
  endtask

  task automatic test_reset_pulse();
    we0 = 1; wn0 = 5; d0 = 32'h12345678;
    tick();
    idle();
    rna = 5;
    #1;
    checks++;
    if (qa !== 32'h12345678) begin
      failures++;
      $display("FAIL pulse_pre got=%h exp=12345678", qa);
    end
    issue = 1; issue_rd = 13; rnb = 13;
    tick();
    issue = 0;
    #1 clrn = 0;
    #1;
    checks++;
    if (qa !== 32'h0 || busy_b !== 1'b0 || busy_cnt !== 6'd0) begin
      failures++;
      $display("FAIL pulse_low got qa=%h bb=%b cnt=%0d exp 0/0/0",
               qa, busy_b, busy_cnt);
    end
    #1 clrn = 1;
    #1;
    checks++;
    if (qa !== 32'h0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL pulse_after got qa=%h bb=%b exp 0/0", qa, busy_b);
    end
    rnb = 0;
  endtask

  task automatic test_write_collision();
    we0 = 1; we1 = 1; wn0 = 7; wn1 = 7;
    d0 = 32'hAAAA0000; d1 = 32'h0000BBBB;
    tick();
    idle();
    rna = 7;
    #1;
    checks++;
    if (qa !== 32'h0000BBBB || qa2 !== 32'h0000BBBB) begin
      failures++;
      $display("FAIL collision got=%h/%h exp=0000bbbb", qa, qa2);
    end
    we0 = 1; wn0 = 8; d0 = 32'h08080808;
    we1 = 1; wn1 = 10; d1 = 32'h10101010;
    tick();
    idle();
    rna = 8; rnb = 10;
    #1;
    checks++;
    if (qa2 !== 32'h08080808 || qb2 !== 32'h10101010) begin
      failures++;
      $display("FAIL dual_write got=%h/%h exp=08080808/10101010",
               qa2, qb2);
    end
  endtask

  task automatic test_bypass();
    we0 = 1; wn0 = 3; d0 = 32'h1111;
    tick();
    idle();
    we0 = 1; wn0 = 3; d0 = 32'hCAFE; rna = 3;
    #1;
    checks++;
    if (qa !== 32'hCAFE) begin
      failures++;
      $display("FAIL bypass_on got=%h exp=cafe", qa);
    end
    checks++;
    if (qa2 !== 32'h1111) begin
      failures++;
      $display("FAIL bypass_off_pre got=%h exp=1111", qa2);
    end
    tick();
    idle();
    #1;
    checks++;
    if (qa2 !== 32'hCAFE) begin
      failures++;
      $display("FAIL bypass_off_post got=%h exp=cafe", qa2);
    end
    we0 = 1; wn0 = 3; d0 = 32'h0D0D;
    we1 = 1; wn1 = 3; d1 = 32'h1D1D; rnb = 3;
    #1;
    checks++;
    if (qb !== 32'h1D1D) begin
      failures++;
      $display("FAIL bypass_prio got=%h exp=1d1d", qb);
    end
    tick();
    idle();
  endtask

  task automatic test_r0();
    we1 = 1; wn1 = 0; d1 = 32'hFFFFFFFF;
    issue = 1; issue_rd = 0; rna = 0;
    #1;
    checks++;
    if (qa !== 32'h0) begin
      failures++;
      $display("FAIL r0_bypass got=%h exp=0", qa);
    end
    tick();
    idle();
    #1;
    checks++;
    if (qa !== 32'h0 || busy_a !== 1'b0 || busy_cnt !== 6'd0) begin
      failures++;
      $display("FAIL r0_state got qa=%h busy=%b cnt=%0d exp 0/0/0",
               qa, busy_a, busy_cnt);
    end
  endtask

  task automatic test_scoreboard();
    issue = 1; issue_rd = 4;
    tick();
    issue_rd = 9;
    tick();
    idle();
    rna = 4; rnb = 9;
    #1;
    checks++;
    if (busy_cnt !== 6'd2 || busy_a !== 1 || busy_b !== 1) begin
      failures++;
      $display("FAIL sb_two got cnt=%0d ba=%b bb=%b exp 2/1/1",
               busy_cnt, busy_a, busy_b);
    end
    we0 = 1; wn0 = 4; issue = 1; issue_rd = 4;
    tick();
    idle();
    checks++;
    if (busy_a !== 1 || busy_cnt !== 6'd2 || ovf !== 0) begin
      failures++;
      $display("FAIL sb_issue_wins got ba=%b cnt=%0d ovf=%b exp 1/2/0",
               busy_a, busy_cnt, ovf);
    end
    we1 = 1; wn1 = 9;
    tick();
    idle();
    checks++;
    if (busy_cnt !== 6'd1 || busy_b !== 0) begin
      failures++;
      $display("FAIL sb_clear got cnt=%0d bb=%b exp 1/0",
               busy_cnt, busy_b);
    end
    issue = 1; issue_rd = 11; we0 = 1; wn0 = 4;
    tick();
    idle();
    rnb = 11;
    #1;
    checks++;
    if (busy_cnt !== 6'd1 || busy_a !== 0 || busy_b !== 1) begin
      failures++;
      $display("FAIL sb_inc_dec got cnt=%0d ba=%b bb=%b exp 1/0/1",
               busy_cnt, busy_a, busy_b);
    end
    issue = 1; issue_rd = 4;
    tick();
    idle();
    we0 = 1; wn0 = 4; we1 = 1; wn1 = 11;
    tick();
    idle();
    checks++;
    if (busy_cnt !== 6'd0 || busy_a !== 0 || busy_b !== 0) begin
      failures++;
      $display("FAIL sb_dec2 got cnt=%0d ba=%b bb=%b exp 0/0/0",
               busy_cnt, busy_a, busy_b);
    end
    we0 = 1; wn0 = 12; d0 = 32'h12;
    tick();
    idle();
    checks++;
    if (busy_cnt !== 6'd0 || ovf !== 0) begin
      failures++;
      $display("FAIL sb_legal_write got cnt=%0d ovf=%b exp 0/0",
               busy_cnt, ovf);
    end
  endtask

  task automatic test_overflow();
    issue = 1; issue_rd = 6;
    tick();
    checks++;
    if (ovf !== 0 || busy_cnt !== 6'd1) begin
      failures++;
      $display("FAIL ovf_first got ovf=%b cnt=%0d exp 0/1", ovf, busy_cnt);
    end
    tick();
    idle();
    checks++;
    if (ovf !== 1 || busy_cnt !== 6'd1) begin
      failures++;
      $display("FAIL ovf_set got ovf=%b cnt=%0d exp 1/1", ovf, busy_cnt);
    end
    we0 = 1; wn0 = 6;
    tick();
    idle();
    tick();
    checks++;
    if (ovf !== 1 || busy_cnt !== 6'd0) begin
      failures++;
      $display("FAIL ovf_sticky got ovf=%b cnt=%0d exp 1/0", ovf, busy_cnt);
    end
    #1 clrn = 0;
    #1;
    checks++;
    if (ovf !== 0) begin
      failures++;
      $display("FAIL ovf_reset got=%b exp=0", ovf);
    end
    #1 clrn = 1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_reset_pulse();
    test_write_collision();
    test_bypass();
    test_r0();
    test_scoreboard();
    test_overflow();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
